// File: rtl/mult4_controller.sv
// Moore sequencer for the 4x4 multiplier datapath: load operands, clear the accumulator,
// step the four 2x2 partial products with shift/accumulate control, then hold done.
module mult4_controller #(
    parameter logic        SEL_HI      = 1'b0,
    parameter int unsigned DONE_CYCLES = 1     // valid range 1..15
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic ld1,
    output logic acc_clr,
    output logic ld2,
    output logic s0,
    output logic s1,
    output logic s2,
    output logic busy,
    output logic done
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StLoad = 3'd1;
    localparam logic [2:0] StPpHh = 3'd2;
    localparam logic [2:0] StPpHl = 3'd3;
    localparam logic [2:0] StPpLh = 3'd4;
    localparam logic [2:0] StPpLl = 3'd5;
    localparam logic [2:0] StDone = 3'd6;

    localparam logic [3:0] DoneLast = 4'(DONE_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic [3:0] done_cnt_q, done_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            done_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        done_cnt_d = done_cnt_q;
        case (state_q)
            StIdle: begin
                done_cnt_d = 4'd0;
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: state_d = StPpHh;
            StPpHh: state_d = StPpHl;
            StPpHl: state_d = StPpLh;
            StPpLh: state_d = StPpLl;
            StPpLl: begin
                state_d    = StDone;
                done_cnt_d = 4'd0;
            end
            StDone: begin
                if (done_cnt_q == DoneLast) begin
                    state_d    = StIdle;
                    done_cnt_d = 4'd0;
                end else begin
                    done_cnt_d = done_cnt_q + 4'd1;
                end
            end
            // Unused encoding recovers to idle.
            default: begin
                state_d    = StIdle;
                done_cnt_d = 4'd0;
            end
        endcase
    end

    // Outputs decoded from state alone, so start never reaches them combinationally.
    always_comb begin
        ld1     = 1'b0;
        acc_clr = 1'b0;
        ld2     = 1'b0;
        s0      = SEL_HI;
        s1      = SEL_HI;
        s2      = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (state_q)
            StIdle: busy = 1'b0;
            StLoad: begin
                ld1     = 1'b1;
                acc_clr = 1'b1;
            end
            StPpHh: ld2 = 1'b1;
            StPpHl: begin
                ld2 = 1'b1;
                s1  = ~SEL_HI;
                s2  = 1'b1;
            end
            StPpLh: begin
                ld2 = 1'b1;
                s0  = ~SEL_HI;
            end
            StPpLl: begin
                ld2 = 1'b1;
                s0  = ~SEL_HI;
                s1  = ~SEL_HI;
                s2  = 1'b1;
            end
            StDone: done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule
